// File: rtl/piso.sv
// Parallel-in / serial-out transmitter.
// Takes WIDTH-bit words on a valid/ready handshake and sends them one bit per
// cycle on a valid/ready serial link. A one-word holding register lets the
// next word queue up while the current one is still shifting, so consecutive
// words stream out with no idle bit between them.
module piso #(
  parameter int WIDTH     = 4,     // word width, >= 2
  parameter bit MSB_FIRST = 1'b1   // 1: bit WIDTH-1 leaves first; 0: bit 0 leaves first
) (
  input  logic             clk_in,
  input  logic             rst,        // asynchronous, active-low
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_out,
  output logic             data_out,
  output logic             valid_out,
  input  logic             ready_in,
  output logic             last_out
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,  // nothing being shifted; hold is always empty here
    SHIFT = 1'b1   // a word occupies the shift register
  } state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   sreg, sreg_nxt, sreg_shifted;
  logic [WIDTH-1:0]   hold, hold_nxt;
  logic               hold_full, hold_full_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;

  logic               accept;     // producer word taken at this edge
  logic               xfer;       // serial bit taken at this edge
  logic               last_xfer;  // final bit of the current word taken

  // Upstream ready depends only on the hold flag and reset, never on an input,
  // so a producer may wait on ready_out without forming a combinational loop.
  assign ready_out = rst & ~hold_full;

  assign valid_out = (state == SHIFT);
  assign data_out  = valid_out & (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]);
  assign last_out  = valid_out & (cnt == LAST_CNT);

  assign accept    = valid_in & ready_out;
  assign xfer      = valid_out & ready_in;
  assign last_xfer = xfer & last_out;

  // Shift the word one place toward the output end, back-filling with zero.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
    end
  end

  // Next-state and datapath decisions for the transmitter.
  always_comb begin
    // NOTE: every signal assigned here gets its hold-value default first, so no
    // branch can leave one unassigned and infer a latch.
    state_nxt     = state;
    sreg_nxt      = sreg;
    cnt_nxt       = cnt;
    hold_nxt      = hold;
    hold_full_nxt = hold_full;

    case (state)
      IDLE: begin
        // Hold is empty in IDLE, so an accepted word goes straight to sreg
        // and its first bit appears on the very next cycle.
        if (accept) begin
          sreg_nxt  = data_in;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end

      SHIFT: begin
        if (last_xfer) begin
          if (hold_full) begin
            // ready_out is low while hold is full, so no accept can race
            // this move; the queued word follows with no gap.
            sreg_nxt      = hold;
            cnt_nxt       = '0;
            hold_full_nxt = 1'b0;
          end else if (accept) begin
            // Word arriving on the final bit skips the holding register.
            sreg_nxt = data_in;
            cnt_nxt  = '0;
          end else begin
            sreg_nxt  = sreg_shifted;
            cnt_nxt   = '0;
            state_nxt = IDLE;
          end
        end else begin
          // Without a transfer everything stays put, so a stalled consumer
          // sees the same bit until it takes it.
          if (xfer) begin
            sreg_nxt = sreg_shifted;
            cnt_nxt  = cnt + CNT_W'(1);
          end
          if (accept) begin
            hold_nxt      = data_in;
            hold_full_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register; reset aborts any word in flight.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process evaluation order.
      state <= state_nxt;
    end
  end

  // Datapath registers: shift register, bit count and holding buffer.
  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      // NOTE: hold contents are cleared along with the flag so a dropped word
      // can never reappear after reset, and outputs read as zero immediately.
      sreg      <= '0;
      cnt       <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      sreg      <= sreg_nxt;
      cnt       <= cnt_nxt;
      hold      <= hold_nxt;
      hold_full <= hold_full_nxt;
    end
  end

endmodule

// File: tb/tb_piso.sv
// Self-checking bench for piso. Three instances cover WIDTH=4 MSB-first,
// WIDTH=4 LSB-first and WIDTH=8 MSB-first. A queue-of-bits model predicts the
// serial stream; a negedge compare process checks every output every cycle,
// and directed tests pin the recorded streams to hand-computed literals.
module tb_piso;

  localparam int NI         = 3;
  localparam int W   [NI]   = '{4, 4, 8};
  localparam bit MSB [NI]   = '{1'b1, 1'b0, 1'b1};

  logic       clk;
  logic       rst;
  logic [7:0] din  [NI];
  logic       vin  [NI];
  logic       rin  [NI];
  logic       rout [NI];
  logic       dout [NI];
  logic       vout [NI];
  logic       lout [NI];

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Expected stream per instance: each entry is {bit, is_last}.
  typedef logic [1:0] bq_t[$];
  bq_t mq [NI];

  // Serial log: bits actually taken by the consumer, newest in bit 0.
  logic [31:0] lbits [NI];
  logic [31:0] llast [NI];
  int          lcnt  [NI];

  piso #(.WIDTH(4), .MSB_FIRST(1'b1)) u0 (
    .clk_in(clk), .rst(rst), .data_in(din[0][3:0]), .valid_in(vin[0]),
    .ready_out(rout[0]), .data_out(dout[0]), .valid_out(vout[0]),
    .ready_in(rin[0]), .last_out(lout[0]));

  piso #(.WIDTH(4), .MSB_FIRST(1'b0)) u1 (
    .clk_in(clk), .rst(rst), .data_in(din[1][3:0]), .valid_in(vin[1]),
    .ready_out(rout[1]), .data_out(dout[1]), .valid_out(vout[1]),
    .ready_in(rin[1]), .last_out(lout[1]));

  piso #(.WIDTH(8), .MSB_FIRST(1'b1)) u2 (
    .clk_in(clk), .rst(rst), .data_in(din[2]), .valid_in(vin[2]),
    .ready_out(rout[2]), .data_out(dout[2]), .valid_out(vout[2]),
    .ready_in(rin[2]), .last_out(lout[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int k, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h", name, k, $time, act, exp);
    end
  endtask

  // Model: the transmitter owes the consumer every bit of every accepted word
  // in order. A word is accepted while at most one word's worth of bits is
  // still owed (hold empty); a bit leaves whenever something is owed and the
  // consumer is ready.
  always @(posedge clk or negedge rst) begin
    int sz;
    int idx;
    bit acc;
    if (!rst) begin
      for (int k = 0; k < NI; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < NI; k++) begin
        sz  = mq[k].size();
        acc = vin[k] && (sz <= W[k]);
        if (sz != 0 && rin[k]) void'(mq[k].pop_front());
        if (acc) begin
          for (int i = 0; i < W[k]; i++) begin
            idx = MSB[k] ? (W[k] - 1 - i) : i;
            mq[k].push_back({din[k][idx], (i == W[k] - 1) ? 1'b1 : 1'b0});
          end
        end
      end
    end
  end

  // Compare every output against the model each cycle and log transfers.
  initial for (int k = 0; k < NI; k++) begin
    lbits[k] = '0; llast[k] = '0; lcnt[k] = 0;
  end

  always @(negedge clk) begin
    int sz;
    logic [1:0] fr;
    if (chk_en) begin
      for (int k = 0; k < NI; k++) begin
        sz = mq[k].size();
        check("valid_out", k, 32'(vout[k]), 32'(sz != 0));
        check("ready_out", k, 32'(rout[k]), 32'(rst && (sz <= W[k])));
        if (sz != 0) begin
          fr = mq[k][0];
          check("data_out", k, 32'(dout[k]), 32'(fr[1]));
          check("last_out", k, 32'(lout[k]), 32'(fr[0]));
        end else begin
          check("data_out_idle", k, 32'(dout[k]), 32'd0);
          check("last_out_idle", k, 32'(lout[k]), 32'd0);
        end
        if (vout[k] && rin[k]) begin
          lbits[k] = {lbits[k][30:0], dout[k]};
          llast[k] = {llast[k][30:0], lout[k]};
          lcnt[k]++;
        end
      end
    end
  end

  // Present one word; returns #1 after the edge that accepted it.
  task automatic send(input int k, input logic [7:0] word);
    bit rdy;
    bit done;
    done = 1'b0;
    din[k] = word;
    vin[k] = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      rdy = rout[k];
      @(posedge clk);
      #1;
      done = rdy;
    end
    vin[k] = 1'b0;
    if (!done) check("send_timeout", k, 32'd0, 32'd1);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Check the last n logged bits and last flags against literals.
  task automatic check_log(input string name, input int k, input int start,
                           input int n, input logic [31:0] bits,
                           input logic [31:0] lasts);
    logic [31:0] mask;
    mask = (32'd1 << n) - 32'd1;
    check({name, "_count"}, k, 32'(lcnt[k] - start), 32'(n));
    check({name, "_bits"},  k, lbits[k] & mask, bits);
    check({name, "_last"},  k, llast[k] & mask, lasts);
  endtask

  initial begin
    int start;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) begin
      din[k] = '0; vin[k] = 1'b0; rin[k] = 1'b1;
    end
    #2;
    chk_en = 1'b1;

    // 1: reset state, then release
    for (int k = 0; k < NI; k++) begin
      check("rst_valid", k, 32'(vout[k]), 32'd0);
      check("rst_ready", k, 32'(rout[k]), 32'd0);
      check("rst_last",  k, 32'(lout[k]), 32'd0);
      check("rst_data",  k, 32'(dout[k]), 32'd0);
    end
    cycles(3);
    rst = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) check("rel_ready", k, 32'(rout[k]), 32'd1);
    cycles(2);

    // 2: single word 1011 MSB first
    start = lcnt[0];
    send(0, 8'b1011);
    check("first_bit_latency", 0, 32'(vout[0]), 32'd1);
    check("first_bit_value",   0, 32'(dout[0]), 32'd1);
    cycles(8);
    check_log("single", 0, start, 4, 32'b1011, 32'b0001);
    check("single_idle", 0, 32'(vout[0]), 32'd0);

    // 3: back-to-back 1011, 0110
    start = lcnt[0];
    send(0, 8'b1011);
    send(0, 8'b0110);
    check("hold_full_ready", 0, 32'(rout[0]), 32'd0);
    cycles(12);
    check_log("b2b", 0, start, 8, 32'b1011_0110, 32'b0001_0001);

    // 4: backpressure after bit 2
    start = lcnt[0];
    send(0, 8'b1011);
    cycles(1);
    rin[0] = 1'b0;
    cycles(3);
    check("bp_data",  0, 32'(dout[0]), 32'd0);
    check("bp_valid", 0, 32'(vout[0]), 32'd1);
    check("bp_last",  0, 32'(lout[0]), 32'd0);
    rin[0] = 1'b1;
    cycles(6);
    check_log("bp", 0, start, 4, 32'b1011, 32'b0001);

    // 5: LSB first and WIDTH=8
    start = lcnt[1];
    send(1, 8'b1011);
    cycles(6);
    check_log("lsb", 1, start, 4, 32'b1101, 32'b0001);
    start = lcnt[2];
    send(2, 8'hA5);
    cycles(10);
    check_log("w8", 2, start, 8, 32'b1010_0101, 32'h01);

    // 6: reset at bit 2 with a word held
    send(0, 8'b1011);
    send(0, 8'b1001);
    #2;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 0, 32'(vout[0]), 32'd0);
    check("mid_rst_data",  0, 32'(dout[0]), 32'd0);
    check("mid_rst_last",  0, 32'(lout[0]), 32'd0);
    check("mid_rst_ready", 0, 32'(rout[0]), 32'd0);
    cycles(3);
    rst = 1'b1;
    cycles(2);
    check("post_rst_idle", 0, 32'(vout[0]), 32'd0);
    start = lcnt[0];
    send(0, 8'b0110);
    cycles(8);
    check_log("post_rst", 0, start, 4, 32'b0110, 32'b0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
